// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, register fields,
// and the grouped enable/flush vectors it drives.
package hazard_ctrl_unit_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, LDSTALL, HALTED} hzd_state_t;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } hzd_en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } hzd_flush_t;

  // A load in ID/EX feeding either source of the instruction in IF/ID; $zero never hazards.
  function automatic logic load_use(input logic memread, input regbits_t wsel,
                                    input regbits_t rs, input regbits_t rt);
    return memread && (wsel != '0) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: one priority chain decides
// per-register enables, bubble insertion, PC hold and the halt latch.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  input  logic             idex_memread,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             br_taken_mem,
  input  logic             jump_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzd_state_t state_q, state_d;
  logic       halt_q, halt_d;
  hzd_en_t    en_c;
  hzd_flush_t fl_c;
  logic       dwait, lu;
  logic       stall_inc, flush_inc;

  assign dwait = (exmem_dren | exmem_dwen) & ~dhit;
  assign lu    = load_use(idex_memread, idex_wsel, ifid_rs, ifid_rt);

  always_comb begin
    en_c    = '1;
    fl_c    = '0;
    state_d = RUN;
    halt_d  = halt_q;
    if (state_q == HALTED) begin
      en_c    = '0;
      state_d = HALTED;
    end else if (halt_wb) begin
      en_c    = '0;
      state_d = HALTED;
      halt_d  = 1'b1;
    end else if (dwait) begin
      en_c    = '0;
      state_d = DWAIT;
    end else if (br_taken_mem) begin
      // Squashes everything younger than the branch, including a load-use victim.
      fl_c = '1;
    end else if (lu && (state_q != LDSTALL)) begin
      en_c.pc   = 1'b0;
      en_c.ifid = 1'b0;
      fl_c.idex = 1'b1;
      state_d   = LDSTALL;
    end else if (!ihit) begin
      en_c.pc   = 1'b0;
      fl_c.ifid = 1'b1;
    end else if (jump_id) begin
      fl_c.ifid = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Held pipeline stays quiet while reset is asserted.
  assign pc_en       = nRST & en_c.pc;
  assign ifid_en     = nRST & en_c.ifid;
  assign idex_en     = nRST & en_c.idex;
  assign exmem_en    = nRST & en_c.exmem;
  assign memwb_en    = nRST & en_c.memwb;
  assign ifid_flush  = nRST & fl_c.ifid;
  assign idex_flush  = nRST & fl_c.idex;
  assign exmem_flush = nRST & fl_c.exmem;
  assign halt        = halt_q;

  assign stall_inc = (state_q != HALTED) & ~en_c.pc;
  assign flush_inc = |fl_c;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .nRST(nRST), .inc(stall_inc), .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .nRST(nRST), .inc(flush_inc), .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with narrow counters so saturation is reachable.
module tb_hazard_ctrl_unit;

  localparam int CNT_W = 4;

  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0, exmem_dren = 1'b0, exmem_dwen = 1'b0;
  logic idex_memread = 1'b0, br_taken_mem = 1'b0, jump_id = 1'b0, halt_wb = 1'b0;
  logic [4:0] idex_wsel = '0, ifid_rs = '0, ifid_rt = '0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .idex_memread(idex_memread), .idex_wsel(idex_wsel),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .br_taken_mem(br_taken_mem), .jump_id(jump_id), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // en = {pc,ifid,idex,exmem,memwb}, fl = {ifid,idex,exmem}
  task automatic chk_out(input string tag, input logic [4:0] en, input logic [2:0] fl);
    chk({tag, "_en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(en));
    chk({tag, "_fl"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(fl));
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(s));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(f));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ihit = 1'b1; dhit = 1'b0; exmem_dren = 1'b0; exmem_dwen = 1'b0;
    idex_memread = 1'b0; idex_wsel = '0; ifid_rs = '0; ifid_rt = '0;
    br_taken_mem = 1'b0; jump_id = 1'b0; halt_wb = 1'b0;
  endtask

  initial begin
    // reset
    clr();
    #12;
    chk_out("rst", 5'b00000, 3'b000);
    chk("rst_halt", 32'(halt), 32'd0);
    chk_cnt("rst", 0, 0);
    nRST = 1'b1;
    tick();

    // idle run
    chk_out("idle", 5'b11111, 3'b000);
    tick(); tick();
    chk_cnt("idle", 0, 0);

    // load-use one-cycle bubble
    idex_memread = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5; #1;
    chk_out("lu", 5'b00111, 3'b010);
    tick();
    chk_out("lu_after", 5'b11111, 3'b000);
    tick();
    chk_cnt("lu", 1, 1);
    idex_wsel = 5'd0; ifid_rs = 5'd0; #1;
    chk_out("lu_r0", 5'b11111, 3'b000);
    idex_wsel = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; #1;
    chk_out("lu_rt", 5'b00111, 3'b010);
    tick();
    clr(); #1;

    // dmem wait with branch parked in EX/MEM
    exmem_dren = 1'b1; br_taken_mem = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("dwait%0d", i), 5'b00000, 3'b000);
      tick();
    end
    chk_cnt("dwait", 5, 2);
    dhit = 1'b1; #1;
    chk_out("dhit_br", 5'b11111, 3'b111);
    tick();
    chk_cnt("dhit_br", 5, 3);
    clr(); #1;

    // branch beats load-use; no LDSTALL, so the load-use fires next cycle
    idex_memread = 1'b1; idex_wsel = 5'd7; ifid_rt = 5'd7; br_taken_mem = 1'b1; #1;
    chk_out("br_lu", 5'b11111, 3'b111);
    tick();
    br_taken_mem = 1'b0; #1;
    chk_out("lu_post_br", 5'b00111, 3'b010);
    tick();
    chk_cnt("br_lu", 6, 5);
    clr(); #1;
    tick();

    // imem miss, jump, and miss over jump
    ihit = 1'b0; #1;
    chk_out("imiss", 5'b01111, 3'b100);
    tick();
    ihit = 1'b1; jump_id = 1'b1; #1;
    chk_out("jump", 5'b11111, 3'b100);
    tick();
    chk_cnt("imiss_jump", 7, 7);
    ihit = 1'b0; exmem_dwen = 1'b1; #1;
    chk_out("store_wait", 5'b00000, 3'b000);
    tick();
    chk_cnt("store_wait", 8, 7);

    // async reset in the middle of DWAIT
    nRST = 1'b0; #1;
    chk_out("rst_mid", 5'b00000, 3'b000);
    chk_cnt("rst_mid", 0, 0);
    clr(); nRST = 1'b1; #1;
    chk_out("rst_rel", 5'b11111, 3'b000);
    tick();
    chk_cnt("rst_rel", 0, 0);

    // saturation: 16 miss cycles on a 4-bit counter
    ihit = 1'b0; #1;
    for (int i = 0; i < 16; i++) tick();
    chk_cnt("sat", 15, 15);
    tick();
    chk_cnt("sat_hold", 15, 15);

    // halt beats dwait and is sticky
    nRST = 1'b0; #1;
    clr(); nRST = 1'b1; #1;
    halt_wb = 1'b1; exmem_dren = 1'b1; #1;
    chk_out("halt_req", 5'b00000, 3'b000);
    chk("halt_pre", 32'(halt), 32'd0);
    tick();
    chk("halt_set", 32'(halt), 32'd1);
    chk_cnt("halt_set", 1, 0);
    clr(); br_taken_mem = 1'b1; jump_id = 1'b1; #1;
    chk_out("halted", 5'b00000, 3'b000);
    tick(); tick();
    chk("halt_sticky", 32'(halt), 32'd1);
    chk_out("halted2", 5'b00000, 3'b000);
    chk_cnt("halted", 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
